mem_port_ctrl: RTL and testbench

//  Memory port between the multicycle RV32I control/datapath (mem_read/mem_write/MAR/MDR) and main memory.

---
 rtl/rv32i_types_pkg.sv | 30 +++
 rtl/mem_align.sv | 80 ++++++++
 rtl/mem_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I encodings plus the memory-port state and request kind.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } memport_state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } memport_kind_t;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - combinational lane logic: byte enables, store steering, load extension, legality.
module mem_align
  import rv32i_types_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Shift the addressed lane down to bit 0 before extending.
  assign rd_byte_sh = rdata >> {addr_lo, 3'b000};
  assign rd_half_sh = rdata >> {addr_lo[1], 4'b0000};
  assign rd_byte    = rd_byte_sh[7:0];
  assign rd_half    = rd_half_sh[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        SB: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        SH: begin
          be         = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
          misaligned = addr_lo[0];
        end
        SW: begin
          be         = 4'b1111;
          wdata_lane = wdata;
          misaligned = (addr_lo != 2'b00);
        end
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB: begin
          be        = 4'b0001 << addr_lo;
          rdata_ext = {{24{rd_byte[7]}}, rd_byte};
        end
        LBU: begin
          be        = 4'b0001 << addr_lo;
          rdata_ext = {24'h0, rd_byte};
        end
        LH: begin
          be         = 4'b0011 << addr_lo;
          rdata_ext  = {{16{rd_half[15]}}, rd_half};
          misaligned = addr_lo[0];
        end
        LHU: begin
          be         = 4'b0011 << addr_lo;
          rdata_ext  = {16'h0, rd_half};
          misaligned = addr_lo[0];
        end
        LW: begin
          be         = 4'b1111;
          rdata_ext  = rdata;
          misaligned = (addr_lo != 2'b00);
        end
        default: misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - CPU memory port: held request -> valid/ready request, response wait, 1-cycle cpu_resp.
// Defining MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES cycles in REQ/WAIT_RSP.
module mem_port_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp,
  output logic        cpu_misaligned,
  output logic        timeout_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  memport_state_t state;
  memport_kind_t  kind_q;
  logic [1:0]     addr_lo_q;
  logic [2:0]     funct3_q;
  logic           timeout_hit;

  logic [2:0]     al_funct3;
  logic [1:0]     al_addr_lo;
  logic           al_is_store;
  logic [3:0]     al_be;
  logic [31:0]    al_wdata;
  logic [31:0]    al_rdata;
  logic           al_misaligned;

  // In IDLE the lane logic decodes the live request; afterwards it decodes the captured one.
  always_comb begin
    al_funct3   = funct3_q;
    al_addr_lo  = addr_lo_q;
    al_is_store = (kind_q == KIND_WRITE);
    if (state == IDLE) begin
      al_funct3   = cpu_funct3;
      al_addr_lo  = cpu_addr[1:0];
      al_is_store = ~cpu_read;
    end
  end

  mem_align u_mem_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_store   (al_is_store),
    .wdata      (cpu_wdata),
    .rdata      (mem_rsp_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      kind_q         <= KIND_READ;
      addr_lo_q      <= 2'b00;
      funct3_q       <= 3'b000;
      cpu_rdata      <= 32'h0;
      cpu_resp       <= 1'b0;
      cpu_misaligned <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= 32'h0;
      mem_req_wdata  <= 32'h0;
      mem_req_be     <= 4'b0000;
    end else begin
      cpu_resp       <= 1'b0;
      cpu_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_read | cpu_write) begin
            kind_q    <= cpu_read ? KIND_READ : KIND_WRITE;
            addr_lo_q <= cpu_addr[1:0];
            funct3_q  <= cpu_funct3;
            if (al_misaligned) begin
              state          <= DONE;
              cpu_resp       <= 1'b1;
              cpu_misaligned <= 1'b1;
              cpu_rdata      <= 32'h0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_we    <= ~cpu_read;
              mem_req_addr  <= {cpu_addr[31:2], 2'b00};
              mem_req_wdata <= al_wdata;
              mem_req_be    <= al_be;
            end
          end
        end
        REQ, WAIT_RSP: begin
          if (timeout_hit) begin
            state         <= DONE;
            cpu_resp      <= 1'b1;
            cpu_rdata     <= 32'h0;
            mem_req_valid <= 1'b0;
          end else if (state == REQ) begin
            if (mem_req_ready) begin
              state         <= WAIT_RSP;
              mem_req_valid <= 1'b0;
            end
          end else if (mem_rsp_valid) begin
            state    <= DONE;
            cpu_resp <= 1'b1;
            if (kind_q == KIND_READ) begin
              cpu_rdata <= al_rdata;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  // Counter is zero whenever REQ is entered because it only runs while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == REQ || state == WAIT_RSP) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (timeout_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_hit = (state == REQ || state == WAIT_RSP) &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_err_q;
`else
  assign timeout_hit = 1'b0;
  // Always 0; written against the parameter so it stays referenced in this build.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed plus randomized checks of mem_port_ctrl against a behavioural model.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [2:0]  cpu_funct3 = 3'b000;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_resp;
  logic        cpu_misaligned;
  logic        timeout_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_funct3     (cpu_funct3),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_resp       (cpu_resp),
    .cpu_misaligned (cpu_misaligned),
    .timeout_err    (timeout_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_tmo   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access size in bytes, 0 for an illegal funct3.
  function automatic int m_size(input bit is_rd, input logic [2:0] f3);
    if (is_rd) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  task automatic clear_inputs();
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  // Called at a sample point in an IDLE cycle; returns at a sample point in the following IDLE cycle.
  task automatic run_access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                            input int rdy_dly, input int rsp_dly);
    bit          is_rd;
    int          sz;
    bit          mis;
    int          e_lat;
    logic [31:0] e_be, e_wd, e_rd, mask, v;
    int          cyc, req_cyc, wait_cyc;
    bit          hs, got, saw_valid, prev_v, prev_r;
    is_rd = rd;
    sz    = m_size(is_rd, f3);
    mis   = (sz == 0) || ((a % sz) != 0);
    e_lat = mis ? 1 : 3 + rdy_dly + rsp_dly;
    e_be  = 32'h0;
    e_wd  = wd;
    e_rd  = m_rdata;
    if (!mis) begin
      e_be = ((32'd1 << sz) - 1) << (a % 4);
      if (sz == 1) e_wd = wd[7:0] * 32'h01010101;
      if (sz == 2) e_wd = wd[15:0] * 32'h00010001;
      if (is_rd) begin
        v = rsp >> (8 * (a % 4));
        if (sz < 4) begin
          mask = (32'd1 << (8 * sz)) - 1;
          v    = v & mask;
          if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
        end
        e_rd = v;
      end
    end else begin
      e_rd = 32'h0;
    end

    cpu_read   = rd;
    cpu_write  = wr;
    cpu_addr   = a;
    cpu_funct3 = f3;
    cpu_wdata  = wd;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    cyc = 0; req_cyc = 0; wait_cyc = 0;
    hs = 0; got = 0; saw_valid = 0; prev_v = 0; prev_r = 0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_v && prev_r) hs = 1;
      if (cpu_resp) begin
        got = 1;
      end else begin
        if (mem_req_valid) begin
          saw_valid = 1;
          req_cyc++;
          check_eq({tag, "/req_addr"}, mem_req_addr, {a[31:2], 2'b00});
          check_eq({tag, "/req_we"}, {31'h0, mem_req_we}, {31'h0, !is_rd});
          check_eq({tag, "/req_be"}, {28'h0, mem_req_be}, e_be);
          if (!is_rd) check_eq({tag, "/req_wdata"}, mem_req_wdata, e_wd);
        end
        if (hs) wait_cyc++;
        mem_req_ready = mem_req_valid && (req_cyc > rdy_dly);
        if (hs) begin
          mem_rsp_valid = (wait_cyc > rsp_dly);
          mem_rsp_rdata = mem_rsp_valid ? rsp : $urandom;
        end else begin
          mem_rsp_valid = 1'($urandom_range(0, 1));
          mem_rsp_rdata = $urandom;
        end
        prev_v = mem_req_valid;
        prev_r = mem_req_ready;
      end
    end
    check_eq({tag, "/resp_seen"}, {31'h0, got}, 32'd1);
    if (got) begin
      check_eq({tag, "/latency"}, cyc, e_lat);
      check_eq({tag, "/misaligned"}, {31'h0, cpu_misaligned}, {31'h0, mis});
      check_eq({tag, "/mem_traffic"}, {31'h0, saw_valid}, {31'h0, !mis});
      check_eq({tag, "/rdata"}, cpu_rdata, e_rd);
      check_eq({tag, "/timeout_err"}, {31'h0, timeout_err}, {31'h0, m_tmo});
      m_rdata = e_rd;
    end
    clear_inputs();
    @(posedge clk); #1;
    check_eq({tag, "/resp_pulse"}, {31'h0, cpu_resp}, 32'd0);
    check_eq({tag, "/mis_low"}, {31'h0, cpu_misaligned}, 32'd0);
    check_eq({tag, "/valid_low"}, {31'h0, mem_req_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          rd, wr;
    int          cyc;
    bit          got;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/rdata", cpu_rdata, 32'h0);
    check_eq("reset/resp", {31'h0, cpu_resp}, 32'd0);
    check_eq("reset/valid", {31'h0, mem_req_valid}, 32'd0);
    check_eq("reset/be", {28'h0, mem_req_be}, 32'd0);
    check_eq("reset/addr", mem_req_addr, 32'h0);
    check_eq("reset/tmo", {31'h0, timeout_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_access("lw_100",   1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0);
    run_access("lb_103",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0);
    run_access("lbu_103",  1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0);
    run_access("sh_102",   0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        4, 0);
    run_access("lh_102",   1, 0, 3'b001, 32'h102, 32'h0,        32'h8001_7FFF, 1, 2);
    run_access("lw_101",   1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0);
    run_access("sh_103",   0, 1, 3'b001, 32'h103, 32'hFFFF,     32'h0,        0, 0);
    run_access("ld_f3_011",1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0);
    run_access("st_f3_100",0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0);
    run_access("both_lw",  1, 1, 3'b010, 32'h204, 32'h11111111, 32'hCAFEF00D, 2, 1);
    run_access("sw_208",   0, 1, 3'b010, 32'h208, 32'hA5A55A5A, 32'h0,        0, 2);

    // Reset while waiting for a response; the late response must be dropped.
    cpu_read = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h300;
    @(posedge clk); #1;
    check_eq("rst/req_valid", {31'h0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; cpu_read = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555AAAA;
    check_eq("rst/valid_drop", {31'h0, mem_req_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst/no_resp", {31'h0, cpu_resp}, 32'd0);
      check_eq("rst/rdata", cpu_rdata, 32'h0);
    end
    mem_rsp_valid = 1'b0;
    m_rdata = 32'h0;
    m_tmo   = 1'b0;
    run_access("lw_after_rst", 1, 0, 3'b010, 32'h400, 32'h0, 32'h0BADC0DE, 0, 0);

    for (int i = 0; i < 120; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (rd ? 3'($urandom_range(0, 1) << 2) : 3'b000);
      a  = $urandom;
      run_access($sformatf("rnd%0d", i), rd, wr, f3, a, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2));
    end

`ifdef MEM_TIMEOUT_EN
    cpu_read = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h500;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_resp) got = 1;
    end
    check_eq("tmo/resp_seen", {31'h0, got}, 32'd1);
    check_eq("tmo/latency", cyc, 9);
    check_eq("tmo/rdata", cpu_rdata, 32'h0);
    check_eq("tmo/err", {31'h0, timeout_err}, 32'd1);
    clear_inputs();
    @(posedge clk); #1;
    m_rdata = 32'h0;
    m_tmo   = 1'b1;
    run_access("tmo_sticky", 1, 0, 3'b010, 32'h504, 32'h0, 32'h12345678, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("tmo/cleared", {31'h0, timeout_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
